// File: rtl/calc_pkg.sv
// calc_pkg -- shared definitions for the bitwise calculator controller.
//   STAGE_W         : width of the FSM state / stage display code
//   ST_*            : FSM state encodings (also shown on the stage display)
//   OP_*            : op_sel codes understood by the bitwise datapath
//   next_op()       : op_sel advance, wrapping 11 -> 00
package calc_pkg;

   localparam int STAGE_W = 3;

   localparam logic [STAGE_W-1:0] ST_IDLE   = 3'd0;
   localparam logic [STAGE_W-1:0] ST_LOAD_A = 3'd1;
   localparam logic [STAGE_W-1:0] ST_LOAD_B = 3'd2;
   localparam logic [STAGE_W-1:0] ST_SEL_OP = 3'd3;
   localparam logic [STAGE_W-1:0] ST_EXEC   = 3'd4;
   localparam logic [STAGE_W-1:0] ST_SHOW   = 3'd5;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_NOT = 2'b10;
   localparam logic [1:0] OP_XOR = 2'b11;

   // Two-bit add naturally wraps OP_XOR back to OP_AND.
   function automatic logic [1:0] next_op(input logic [1:0] op);
      return op + 2'b01;
   endfunction

endpackage

// File: rtl/btn_pulse.sv
// btn_pulse -- raw push button to single-cycle press pulse.
//   clk, reset : system clock, asynchronous active-high reset
//   btn        : raw, unsynchronised, bouncing button input
//   pulse      : one-cycle high pulse per qualified press
// A 2-flop synchroniser feeds a debouncer: the debounced level only flips
// after the synchronised input has disagreed with it for DB_CYCLES
// consecutive cycles. The pulse fires on the 0->1 flip of that level, so a
// new press is only accepted after a qualified release.
module btn_pulse #(
   parameter int DB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic pulse
);

   localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             level_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q  <= 2'b00;
         level_q <= 1'b0;
         cnt_q   <= '0;
         pulse   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn};
         pulse  <= 1'b0;
         if (sync_q[1] != level_q) begin
            // cnt_q holds how many earlier consecutive cycles disagreed;
            // this cycle is the DB_CYCLES-th one when it reaches CNT_LAST.
            if (cnt_q == CNT_LAST) begin
               level_q <= sync_q[1];
               cnt_q   <= '0;
               pulse   <= sync_q[1];
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

endmodule

// File: rtl/bitwise_ctrl.sv
// bitwise_ctrl -- operator-driven controller for a bitwise datapath.
//   clk, reset      : system clock, asynchronous active-high reset
//   enable          : bitwise mode selected; low forces IDLE
//   sw[7:0]         : operand switches
//   btn_confirm/back/next : raw push buttons
//   result_in[7:0]  : combinational result from the datapath
//   op_a, op_b      : registered operands to the datapath
//   op_sel[1:0]     : operation code (AND, OR, NOT a, XOR)
//   alu_en          : datapath enable, high only in EXEC
//   stage[2:0]      : current FSM state, for the stage display
//   led[7:0]        : registered LED value
//   result_valid    : high while in SHOW
// Handshake: result_valid is a level qualifier with no ready; while it is
// high, led carries the result register (from the second SHOW cycle on,
// since led lags state by one cycle) and op_a/op_b/op_sel are stable.
module bitwise_ctrl
   import calc_pkg::*;
#(
   parameter int DB_CYCLES = 1000000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [7:0]         sw,
   input  logic               btn_confirm,
   input  logic               btn_back,
   input  logic               btn_next,
   input  logic [7:0]         result_in,
   output logic [7:0]         op_a,
   output logic [7:0]         op_b,
   output logic [1:0]         op_sel,
   output logic               alu_en,
   output logic [STAGE_W-1:0] stage,
   output logic [7:0]         led,
   output logic               result_valid
);

   logic [STAGE_W-1:0] state_q;
   logic [7:0]         result_q;
   logic [7:0]         led_next;
   logic               p_confirm, p_back, p_next;
   logic               do_confirm, do_back, do_next;

   btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_confirm (
      .clk(clk), .reset(reset), .btn(btn_confirm), .pulse(p_confirm)
   );
   btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_back (
      .clk(clk), .reset(reset), .btn(btn_back), .pulse(p_back)
   );
   btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_next (
      .clk(clk), .reset(reset), .btn(btn_next), .pulse(p_next)
   );

   // Priority confirm > back > next; losers in the same cycle are dropped.
   assign do_confirm = p_confirm;
   assign do_back    = p_back & ~p_confirm;
   assign do_next    = p_next & ~p_confirm & ~p_back;

   // LED follows the state and switches of the previous cycle.
   always_comb begin
      led_next = 8'h00;
      case (state_q)
         ST_IDLE:   led_next = 8'h00;
         ST_LOAD_A: led_next = sw;
         ST_LOAD_B: led_next = sw;
         ST_SEL_OP: led_next = {6'b0, op_sel};
         ST_EXEC:   led_next = led;
         ST_SHOW:   led_next = result_q;
         default:   led_next = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         op_a     <= 8'h00;
         op_b     <= 8'h00;
         op_sel   <= OP_AND;
         result_q <= 8'h00;
         led      <= 8'h00;
      end else begin
         led <= led_next;
         if (!enable) begin
            // Operands and op_sel survive leaving bitwise mode.
            state_q  <= ST_IDLE;
            result_q <= 8'h00;
         end else begin
            case (state_q)
               ST_IDLE: state_q <= ST_LOAD_A;
               ST_LOAD_A: begin
                  if (do_confirm) begin
                     op_a    <= sw;
                     state_q <= ST_LOAD_B;
                  end
               end
               ST_LOAD_B: begin
                  if (do_confirm) begin
                     op_b    <= sw;
                     state_q <= ST_SEL_OP;
                  end else if (do_back) begin
                     state_q <= ST_LOAD_A;
                  end
               end
               ST_SEL_OP: begin
                  if (do_confirm)      state_q <= ST_EXEC;
                  else if (do_back)    state_q <= ST_LOAD_B;
                  else if (do_next)    op_sel  <= next_op(op_sel);
               end
               ST_EXEC: begin
                  result_q <= result_in;
                  state_q  <= ST_SHOW;
               end
               ST_SHOW: begin
                  if (do_confirm) begin
                     state_q <= ST_LOAD_A;
                  end else if (do_back) begin
                     state_q <= ST_SEL_OP;
                  end else if (do_next) begin
                     op_sel  <= next_op(op_sel);
                     state_q <= ST_EXEC;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign alu_en       = (state_q == ST_EXEC);
   assign result_valid = (state_q == ST_SHOW);
   assign stage        = state_q;

endmodule

// File: tb/tb_bitwise_ctrl.sv
// tb_bitwise_ctrl -- directed bench for bitwise_ctrl with DB_CYCLES=4.
// The bench models the external bitwise datapath. Each operation expected
// to end in SHOW pushes {op_a, op_b, op_sel, led} onto exp_q; a monitor pops
// one entry every time result_valid rises and compares once led settles.
module tb_bitwise_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [7:0] sw = 8'h00;
   logic       btn_confirm = 1'b0;
   logic       btn_back = 1'b0;
   logic       btn_next = 1'b0;
   logic [7:0] result_in;
   logic [7:0] op_a, op_b, led;
   logic [1:0] op_sel;
   logic       alu_en, result_valid;
   logic [2:0] stage;

   int n_vec = 0;
   int n_err = 0;
   int alu_cnt = 0;
   logic [25:0] exp_q[$];

   bitwise_ctrl #(.DB_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .enable(enable), .sw(sw),
      .btn_confirm(btn_confirm), .btn_back(btn_back), .btn_next(btn_next),
      .result_in(result_in), .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
      .alu_en(alu_en), .stage(stage), .led(led), .result_valid(result_valid)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- datapath model ----------------
   always_comb begin
      case (op_sel)
         2'b00:   result_in = op_a & op_b;
         2'b01:   result_in = op_a | op_b;
         2'b10:   result_in = ~op_a;
         default: result_in = op_a ^ op_b;
      endcase
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      logic rv_prev;
      rv_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (result_valid && !rv_prev) begin
            rv_prev = 1'b1;
            @(negedge clk);
            if (exp_q.size() == 0) begin
               check("show_unexpected", {6'b0, op_a, op_b, op_sel, led}, 32'hFFFF_FFFF);
            end else begin
               check("show_vec", {6'b0, op_a, op_b, op_sel, led}, {6'b0, exp_q.pop_front()});
            end
         end else begin
            rv_prev = result_valid;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (alu_en) alu_cnt++;
      end
   end

   initial begin
      #100000;
      n_vec++;
      n_err++;
      $display("FAIL timeout: simulation exceeded time budget");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // ---------------- drivers ----------------
   // m[0]=confirm, m[1]=back, m[2]=next; held and released long enough to
   // qualify both edges through synchroniser + debouncer.
   task automatic press(input logic [2:0] m);
      @(posedge clk); #1;
      btn_confirm = m[0];
      btn_back    = m[1];
      btn_next    = m[2];
      repeat (10) @(posedge clk);
      #1;
      btn_confirm = 1'b0;
      btn_back    = 1'b0;
      btn_next    = 1'b0;
      repeat (10) @(posedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] res_tab[4];
      logic [2:0] prev_stage;
      int         changes;
      res_tab[0] = 8'h30; res_tab[1] = 8'hFC; res_tab[2] = 8'h0F; res_tab[3] = 8'hCC;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_stage", {29'b0, stage}, 32'd0);
      check("rst_op_a", {24'b0, op_a}, 32'h00);
      check("rst_led", {24'b0, led}, 32'h00);
      check("rst_flags", {30'b0, alu_en, result_valid}, 32'd0);
      @(posedge clk); #1;
      reset  = 1'b0;
      enable = 1'b1;
      @(posedge clk); @(negedge clk);
      check("idle_to_load_a", {29'b0, stage}, 32'd1);

      // back is ignored in LOAD_A
      press(3'b010);
      @(negedge clk);
      check("back_in_load_a", {29'b0, stage}, 32'd1);

      // bouncing confirm: exactly one accepted press
      sw = 8'hF0;
      prev_stage = stage;
      changes = 0;
      for (int i = 0; i < 26; i++) begin
         @(posedge clk); #1;
         if (i < 6)       btn_confirm = (i % 2 == 0);
         else if (i < 16) btn_confirm = 1'b1;
         else             btn_confirm = 1'b0;
         @(negedge clk);
         if (stage != prev_stage) changes++;
         prev_stage = stage;
      end
      check("bounce_one_pulse", changes, 32'd1);
      check("bounce_stage", {29'b0, stage}, 32'd2);
      check("op_a_latched", {24'b0, op_a}, 32'hF0);
      sw = 8'h3C;
      @(negedge clk);
      check("led_follows_sw", {24'b0, led}, 32'h3C);

      // confirm + back together in LOAD_B: confirm wins
      press(3'b011);
      @(negedge clk);
      check("cb_stage", {29'b0, stage}, 32'd3);
      check("op_b_latched", {24'b0, op_b}, 32'h3C);
      check("sel_op_led", {24'b0, led}, 32'h00);

      // execute AND
      exp_q.push_back({8'hF0, 8'h3C, 2'b00, 8'h30});
      press(3'b001);
      @(negedge clk);
      check("alu_one_cycle", alu_cnt, 32'd1);
      check("show_valid", {31'b0, result_valid}, 32'd1);

      // next in SHOW cycles OR, NOT, XOR, then wraps to AND
      for (int k = 1; k <= 4; k++) begin
         exp_q.push_back({8'hF0, 8'h3C, 2'(k % 4), res_tab[k % 4]});
         press(3'b100);
      end
      @(negedge clk);
      check("alu_count_5", alu_cnt, 32'd5);

      // back to SEL_OP, advance op, execute again
      press(3'b010);
      @(negedge clk);
      check("show_back", {29'b0, stage}, 32'd3);
      press(3'b100);
      @(negedge clk);
      check("sel_op_next_led", {24'b0, led}, 32'h01);
      exp_q.push_back({8'hF0, 8'h3C, 2'b01, 8'hFC});
      press(3'b001);
      @(negedge clk);
      check("show_again", {29'b0, stage}, 32'd5);

      // drop enable in SHOW
      @(posedge clk); #1;
      enable = 1'b0;
      @(posedge clk); @(negedge clk);
      check("dis_stage", {29'b0, stage}, 32'd0);
      check("dis_valid", {31'b0, result_valid}, 32'd0);
      repeat (2) @(negedge clk);
      check("dis_led", {24'b0, led}, 32'h00);
      check("dis_op_a_kept", {24'b0, op_a}, 32'hF0);
      check("dis_op_sel_kept", {30'b0, op_sel}, 32'd1);

      // async reset mid SEL_OP
      @(posedge clk); #1;
      enable = 1'b1;
      sw = 8'h55;
      press(3'b000);
      press(3'b001);
      sw = 8'hAA;
      press(3'b001);
      @(negedge clk);
      check("pre_rst_stage", {29'b0, stage}, 32'd3);
      check("pre_rst_ops", {16'b0, op_a, op_b}, 32'h55AA);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      check("arst_stage", {29'b0, stage}, 32'd0);
      check("arst_ops", {14'b0, op_a, op_b, op_sel}, 32'd0);
      check("arst_outs", {22'b0, led, alu_en, result_valid}, 32'd0);

      // button held across reset release must not produce a press
      #1;
      btn_confirm = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      btn_confirm = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      check("rst_midpress_stage", {29'b0, stage}, 32'd1);
      check("rst_midpress_op_a", {24'b0, op_a}, 32'h00);

      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
